// File: rtl/img_seq_pkg.sv
// Shared types and helpers for the image frame sequencer: state encoding,
// default widths and the BMP row-stride helper.
package img_seq_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VS,
        ST_VBP,
        ST_LINE,
        ST_HBL,
        ST_VFP
    } seq_state_t;

    // Bytes per stored row: 3 bytes per pixel, padded up to a multiple of 4.
    function automatic logic [31:0] calc_stride(input logic [31:0] width);
        return (width * 32'd3 + 32'd3) & ~32'd3;
    endfunction

endpackage

// File: rtl/img_seq_addr_gen.sv
// Pixel-store address generator: owns stride, row_base and col, and drives a
// registered pix_addr that is non-zero only while a line is being emitted.
// Optional SEQ_BOTTOM_UP_EN walks a bottom-up BMP store in raster order.
module img_seq_addr_gen
    import img_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  img_width,
`ifdef SEQ_BOTTOM_UP_EN
    input  logic [CNT_W-1:0]  img_height,
`endif
    input  logic              line_start,
    input  logic              next_pix,
    input  logic              next_line,
    input  logic              reload,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [CNT_W-1:0]  col
);

    logic [ADDR_W-1:0] stride_c;
    logic [ADDR_W-1:0] first_c;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] first_row_q;
    logic [ADDR_W-1:0] row_base_q;

    assign stride_c = ADDR_W'(calc_stride(32'(img_width)));

`ifdef SEQ_BOTTOM_UP_EN
    assign first_c = base_addr + (ADDR_W'(img_height) - ADDR_W'(1)) * stride_c;
`else
    assign first_c = base_addr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q    <= '0;
            first_row_q <= '0;
            row_base_q  <= '0;
            pix_addr    <= '0;
            col         <= '0;
        end else begin
            if (load) begin
                stride_q    <= stride_c;
                first_row_q <= first_c;
                row_base_q  <= first_c;
            end else if (reload) begin
                row_base_q <= first_row_q;
            end else if (next_line) begin
`ifdef SEQ_BOTTOM_UP_EN
                row_base_q <= row_base_q - stride_q;
`else
                row_base_q <= row_base_q + stride_q;
`endif
            end

            // Incrementing by 3 keeps pix_addr == row_base + 3*col without a multiplier.
            if (line_start) begin
                pix_addr <= row_base_q;
                col      <= '0;
            end else if (next_pix) begin
                pix_addr <= pix_addr + ADDR_W'(3);
                col      <= col + CNT_W'(1);
            end else begin
                pix_addr <= '0;
                col      <= '0;
            end
        end
    end

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame sequencer: emits vsync/href timing and BMP pixel addresses for a
// programmed run of frames, with start/busy/done handshake and abort.
// Build option SEQ_BOTTOM_UP_EN selects bottom-up row order.
module img_frame_sequencer
    import img_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 8,
    parameter int H_BLANK   = 16,
    parameter int V_FRONT   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        frames,
    input  logic [CNT_W-1:0]  img_width,
    input  logic [CNT_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              vsync,
    output logic              href,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        frame_idx
);

    localparam int PH_W = 16;

    seq_state_t       state;
    logic [PH_W-1:0]  cnt;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] height_q;
    logic [3:0]       frames_q;

    logic zero_cfg, vs_end, vbp_end, hbl_end, vfp_end;
    logic line_end, last_line, last_frame;
    logic load, line_start, next_pix, next_line, reload;

    assign zero_cfg   = (frames == 4'd0) || (img_width == '0) || (img_height == '0);
    assign vs_end     = (cnt == PH_W'(VSYNC_LEN - 1));
    assign vbp_end    = (cnt == PH_W'(V_BACK - 1));
    assign hbl_end    = (cnt == PH_W'(H_BLANK - 1));
    assign vfp_end    = (cnt == PH_W'(V_FRONT - 1));
    assign line_end   = (col == width_q - CNT_W'(1));
    assign last_line  = (row == height_q - CNT_W'(1));
    assign last_frame = (frame_idx == frames_q - 4'd1);

    // Address strobes mirror the transitions taken by the FSM below; abort suppresses them.
    always_comb begin
        load       = 1'b0;
        line_start = 1'b0;
        next_pix   = 1'b0;
        next_line  = 1'b0;
        reload     = 1'b0;
        if (state == ST_IDLE) begin
            load = start && !zero_cfg;
        end else if (!abort) begin
            case (state)
                ST_VBP:  line_start = vbp_end;
                ST_LINE: begin
                    next_pix  = !line_end;
                    next_line = line_end && !last_line;
                end
                ST_HBL:  line_start = hbl_end;
                ST_VFP:  reload = vfp_end && !last_frame;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            row       <= '0;
            width_q   <= '0;
            height_q  <= '0;
            frames_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vsync     <= 1'b0;
            href      <= 1'b0;
            frame_idx <= '0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                row       <= '0;
                busy      <= 1'b0;
                vsync     <= 1'b0;
                href      <= 1'b0;
                frame_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        if (zero_cfg) begin
                            done <= 1'b1;
                        end else begin
                            frames_q  <= frames;
                            width_q   <= img_width;
                            height_q  <= img_height;
                            busy      <= 1'b1;
                            vsync     <= 1'b1;
                            cnt       <= '0;
                            row       <= '0;
                            frame_idx <= '0;
                            state     <= ST_VS;
                        end
                    end
                    ST_VS: if (vs_end) begin
                        vsync <= 1'b0;
                        cnt   <= '0;
                        state <= ST_VBP;
                    end else begin
                        cnt <= cnt + PH_W'(1);
                    end
                    ST_VBP: if (vbp_end) begin
                        href  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_LINE;
                    end else begin
                        cnt <= cnt + PH_W'(1);
                    end
                    ST_LINE: if (line_end) begin
                        href <= 1'b0;
                        cnt  <= '0;
                        if (last_line) begin
                            state <= ST_VFP;
                        end else begin
                            row   <= row + CNT_W'(1);
                            state <= ST_HBL;
                        end
                    end
                    ST_HBL: if (hbl_end) begin
                        href  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_LINE;
                    end else begin
                        cnt <= cnt + PH_W'(1);
                    end
                    ST_VFP: if (vfp_end) begin
                        cnt <= '0;
                        row <= '0;
                        if (last_frame) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            frame_idx <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            frame_idx <= frame_idx + 4'd1;
                            vsync     <= 1'b1;
                            state     <= ST_VS;
                        end
                    end else begin
                        cnt <= cnt + PH_W'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    img_seq_addr_gen #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .base_addr (base_addr),
        .img_width (img_width),
`ifdef SEQ_BOTTOM_UP_EN
        .img_height(img_height),
`endif
        .line_start(line_start),
        .next_pix  (next_pix),
        .next_line (next_line),
        .reload    (reload),
        .pix_addr  (pix_addr),
        .col       (col)
    );

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Scoreboard bench for img_frame_sequencer: a frame/row/column model fills an
// expected queue of {frame_idx, pix_addr}; a negedge monitor pops on every href.
module tb_img_frame_sequencer;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 12;
    localparam int VS_LEN = 4;
    localparam int V_BK   = 8;
    localparam int H_BL   = 16;
    localparam int V_FR   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [3:0]        frames;
    logic [CNT_W-1:0]  img_width;
    logic [CNT_W-1:0]  img_height;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              vsync;
    logic              href;
    logic [ADDR_W-1:0] pix_addr;
    logic [3:0]        frame_idx;

    img_frame_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .VSYNC_LEN(VS_LEN),
        .V_BACK(V_BK), .H_BLANK(H_BL), .V_FRONT(V_FR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .frames(frames), .img_width(img_width), .img_height(img_height),
        .base_addr(base_addr), .busy(busy), .done(done), .vsync(vsync),
        .href(href), .pix_addr(pix_addr), .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [35:0] exp_q[$];
    int   vs_rises;
    int   done_cnt;
    int   vs_len;
    int   last_rise;
    int   exp_frame_len;
    logic prev_vsync = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int frame_len(input int w, input int h);
        return VS_LEN + V_BK + h * w + (h - 1) * H_BL + V_FR;
    endfunction

    // Reference: every frame visits every stored row once, pixels left to right.
    function automatic void push_run(input int f, input int w, input int h, input logic [31:0] base);
        logic [31:0] stride;
        logic [31:0] addr;
        int          row;
        stride = 32'(((3 * w + 3) / 4) * 4);
        for (int fr = 0; fr < f; fr++)
            for (int r = 0; r < h; r++) begin
`ifdef SEQ_BOTTOM_UP_EN
                row = h - 1 - r;
`else
                row = r;
`endif
                for (int c = 0; c < w; c++) begin
                    addr = base + 32'(row) * stride + 32'(3 * c);
                    exp_q.push_back({4'(fr), addr});
                end
            end
    endfunction

    always @(negedge clk) begin : monitor
        logic [35:0] e;
        if (rst_n) begin
            if (href) begin
                if (exp_q.size() == 0) begin
                    check("href_unexpected", 64'(href), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix", 64'({frame_idx, pix_addr}), 64'(e));
                end
                check("busy_in_line", 64'(busy), 64'd1);
            end
            if (vsync && !prev_vsync) begin
                vs_rises++;
                if (vs_rises > 1) check("vsync_spacing", 64'(cyc - last_rise), 64'(exp_frame_len));
                last_rise = cyc;
            end
            if (vsync) vs_len++;
            else if (vs_len != 0) begin
                check("vsync_len", 64'(vs_len), 64'(VS_LEN));
                vs_len = 0;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            prev_vsync = vsync;
        end
    end

    task automatic issue_start(input int f, input int w, input int h, input logic [31:0] base, input bit with_abort);
        @(negedge clk);
        frames     = 4'(f);
        img_width  = CNT_W'(w);
        img_height = CNT_W'(h);
        base_addr  = base;
        start      = 1'b1;
        abort      = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run(input int f, input int w, input int h, input logic [31:0] base,
                       input bit with_abort, input bit busy_start);
        int t0;
        int elapsed;
        bit seen;
        int budget;
        vs_rises = 0;
        done_cnt = 0;
        vs_len   = 0;
        exp_q.delete();
        if (f == 0 || w == 0 || h == 0) begin
            issue_start(f, w, h, base, with_abort);
            check("zero_done", 64'(done), 64'd1);
            check("zero_busy", 64'(busy), 64'd0);
            repeat (4) @(posedge clk);
            #1;
            check("zero_vsync_count", 64'(vs_rises), 64'd0);
            check("zero_done_count", 64'(done_cnt), 64'd1);
        end else begin
            exp_frame_len = frame_len(w, h);
            push_run(f, w, h, base);
            issue_start(f, w, h, base, with_abort);
            t0      = cyc;
            seen    = 1'b0;
            elapsed = 0;
            budget  = f * exp_frame_len + 40;
            for (int k = 0; k < budget; k++) begin
                @(negedge clk);
                start = busy_start && (k == 10);
                if (busy_start && k == 10) img_width = CNT_W'(w + 3);
                if (done) begin
                    seen    = 1'b1;
                    elapsed = cyc - t0;
                    break;
                end
            end
            start     = 1'b0;
            img_width = CNT_W'(w);
            check("done_seen", 64'(seen), 64'd1);
            check("run_cycles", 64'(elapsed), 64'(f * exp_frame_len));
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(done), 64'd0);
            check("done_count", 64'(done_cnt), 64'd1);
            check("vsync_count", 64'(vs_rises), 64'(f));
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("busy_after", 64'(busy), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic abort_test();
        bit seen;
        vs_rises = 0;
        done_cnt = 0;
        vs_len   = 0;
        exp_q.delete();
        exp_frame_len = frame_len(8, 3);
        push_run(2, 8, 3, 32'd200);
        issue_start(2, 8, 3, 32'd200, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (href) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_href_seen", 64'(seen), 64'd1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_href", 64'(href), 64'd0);
        check("abort_vsync", 64'(vsync), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pix_addr", 64'(pix_addr), 64'd0);
        check("abort_frame_idx", 64'(frame_idx), 64'd0);
        exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_stays_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        frames     = '0;
        img_width  = '0;
        img_height = '0;
        base_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_vsync", 64'(vsync), 64'd0);
        check("rst_href", 64'(href), 64'd0);
        check("rst_pix_addr", 64'(pix_addr), 64'd0);
        check("rst_frame_idx", 64'(frame_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1, 4, 2, 32'd54, 1'b0, 1'b0);
        run(1, 5, 2, 32'd54, 1'b0, 1'b0);
        run(2, 4, 2, 32'd54, 1'b0, 1'b0);
        run(1, 4, 0, 32'd54, 1'b0, 1'b0);
        run(0, 3, 3, 32'd54, 1'b0, 1'b0);
        run(1, 0, 2, 32'd54, 1'b0, 1'b0);
        run(1, 4, 2, 32'd54, 1'b0, 1'b1);
        run(2, 3, 2, 32'd100, 1'b1, 1'b0);
        run(1, 6, 3, 32'hFFFF_FFF0, 1'b0, 1'b0);

        // Abort while idle must leave the block idle.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_vsync", 64'(vsync), 64'd0);

        abort_test();

        for (int i = 0; i < 6; i++)
            run($urandom_range(1, 3), $urandom_range(1, 9), $urandom_range(1, 4),
                $urandom, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_frame_sequencer.md
# img_frame_sequencer

Frame sequencer for the image-processing datapath. It generates camera-style frame timing (vsync, href) and a byte address into a BMP-layout pixel store for a programmed number of frames. It replaces the free-running camera model as the source that paces the median filter and related filters. It also provides start/busy/done sequencing so that a capture stage can know exactly when a run of frames has finished.

## Interface
Parameters:
- ADDR_W, 32, width of byte addresses
- CNT_W, 12, width of width/height counters
- VSYNC_LEN, 4, vsync high cycles per frame (≥1)
- V_BACK, 8, idle cycles between vsync fall and first line (≥1)
- H_BLANK, 16, idle cycles between lines (≥1)
- V_FRONT, 8, idle cycles after last line (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a run; ignored while busy
- abort  in  1  synchronous stop of a run in progress
- frames  in  4  number of frames per run
- img_width  in  CNT_W  pixels per line
- img_height  in  CNT_W  lines per frame
- base_addr  in  ADDR_W  byte offset of the first pixel byte (54 for plain BMP)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal run completion
- vsync  out  1  frame-start pulse, active high
- href  out  1  active-pixel qualifier
- pix_addr  out  ADDR_W  byte address of the B byte of the current pixel
- frame_idx  out  4  index of the current frame within the run, counting from 0

## Operation
- The states are IDLE, VS, VBP, LINE, HBL and VFP.
- IDLE: all outputs are 0.
  - start is sampled while in IDLE. On that edge the block latches frames, img_width, img_height and base_addr.
  - It computes stride = (3·width + 3) & ~3, which pads each row to a multiple of 4 bytes as BMP requires.
  - If frames, width or height is 0, it pulses done for one cycle and stays in IDLE. No vsync is produced.
  - Otherwise it sets busy and moves to VS.
- VS holds vsync=1 for VSYNC_LEN cycles, then goes to VBP.
- VBP lasts V_BACK cycles, then goes to LINE.
- LINE holds href=1 for width cycles. pix_addr = row_base + 3·col, with col running 0..width−1.
  - After a line that is not the last, go to HBL.
  - After the last line, go directly to VFP.
- HBL lasts H_BLANK cycles. row_base advances by one stride, then the block returns to LINE.
- VFP lasts V_FRONT cycles.
  - If frame_idx = frames−1: go to IDLE, pulse done, clear busy.
  - Otherwise: increment frame_idx, reload row_base and go to VS.
- Row order defaults to storage order. row_base starts at base_addr and increases by stride each line.
- abort, when asserted in any non-IDLE state, sends the block to IDLE on the next edge with all outputs at 0 and no done pulse. abort in IDLE has no effect. If abort and start are high in the same IDLE cycle, start wins.
- start while busy is ignored. Latched parameters do not change within a run.
- Asynchronous reset puts the block in IDLE, clears every output to 0 and clears all counters.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W with no error flag.

## Timing
- All outputs are registered.
- vsync is first high in the cycle after start is sampled.
- pix_addr is valid in the same cycle as href. The pixel store has 1-cycle read latency, so pixel data lags href by one cycle, and the consumer delays href to match.
- Frame length in cycles = VSYNC_LEN + V_BACK + height·width + (height−1)·H_BLANK + V_FRONT.
- Consecutive frames are back-to-back: VS follows VFP immediately.
- done is high for exactly one cycle, in the first IDLE cycle; busy is 0 in that same cycle.
- A new start is accepted in the same cycle that done is high.

## Configuration
- SEQ_BOTTOM_UP_EN: when defined, lines are emitted in raster order from a bottom-up BMP store.
  - row_base starts at base_addr + (height−1)·stride and decreases by stride each line.
  - This start address is computed in the latch cycle.
- When the macro is not defined, the block uses storage order, and the multiplier is not present.

## Structure
- A shared package img_seq_pkg holds:
  - the state enum
  - default CNT_W and ADDR_W
  - the stride helper function
- There is one sub-module, img_seq_addr_gen. It owns row_base, col and stride, and produces pix_addr from load, next_pix and next_line strobes issued by the FSM.

## Test plan
- width=4, height=2, base=54, frames=1 → line 0 addresses 54, 57, 60, 63; line 1 addresses 66, 69, 72, 75. Exactly 8 href cycles, one vsync pulse of 4 cycles, then done.
- width=5 → stride=16. Line 1 starts at base+16, which checks row padding.
- SEQ_BOTTOM_UP_EN with width=4, height=2, base=54 → line 0 starts at 66, line 1 starts at 54.
- frames=2 → two vsync pulses spaced exactly one frame length apart; frame_idx goes 0 then 1; a single done pulse.
- Measure the cycle count from start to done against the frame-length formula, using the default parameters and width=4, height=2.
- Boundary cases:
  - abort in mid-line → href, vsync and busy are 0 on the next cycle, with no done pulse.
  - height=0 → done on the next cycle with no vsync.
  - start while busy → ignored.
